// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: phase enumeration, counter width and default
// horizontal/vertical phase widths used by both timing stages.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;

  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_t;

  function automatic phase_t next_phase(input phase_t cur);
    case (cur)
      PH_SYNC:   next_phase = PH_BACK;
      PH_BACK:   next_phase = PH_ACTIVE;
      PH_ACTIVE: next_phase = PH_FRONT;
      default:   next_phase = PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/h_timing_gen.sv
// Horizontal VGA timing generator: phase FSM plus line position, visible
// column and an end-of-line pulse for the vertical stage.
module h_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF
) (
  input  logic             clkh,
  input  logic             clrh,
  input  logic             pix_en,
  output logic [CNT_W-1:0] cntrh,
  output logic             hs,
  output logic             de,
  output logic [CNT_W-1:0] pix_x,
  output logic             line_tick
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;

  if (H_TOTAL > 1024) begin : g_total_check
    $error("h_timing_gen: H_TOTAL exceeds 10-bit counter range");
  end

  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(H_SYNC - 1);
  localparam logic [CNT_W-1:0] BACK_LAST   = CNT_W'(H_BP - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] FRONT_LAST  = CNT_W'(H_FP - 1);

  phase_t           state;
  phase_t           nxt_state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] phase_last;
  logic             phase_end;
  logic             wrap;

  always_comb begin
    phase_last = SYNC_LAST;
    case (state)
      PH_SYNC:   phase_last = SYNC_LAST;
      PH_BACK:   phase_last = BACK_LAST;
      PH_ACTIVE: phase_last = ACTIVE_LAST;
      default:   phase_last = FRONT_LAST;
    endcase
  end

  assign phase_end = (phase_cnt == phase_last);
  assign nxt_state = phase_end ? next_phase(state) : state;
  // The line ends exactly when the FSM leaves FRONT, so cntrh wraps on that tick.
  assign wrap      = phase_end && (state == PH_FRONT);

  always_ff @(posedge clkh) begin
    if (!clrh) begin
      state     <= PH_SYNC;
      phase_cnt <= '0;
      cntrh     <= '0;
      hs        <= 1'b0;
      de        <= 1'b0;
      pix_x     <= '0;
      line_tick <= 1'b0;
    end else begin
      line_tick <= 1'b0;
      if (pix_en) begin
        state     <= nxt_state;
        phase_cnt <= phase_end ? '0 : phase_cnt + CNT_W'(1);
        cntrh     <= wrap ? '0 : cntrh + CNT_W'(1);
        line_tick <= wrap;
        // Outputs are decoded from the next state so they line up with cntrh.
        hs        <= (nxt_state != PH_SYNC);
        de        <= (nxt_state == PH_ACTIVE);
        pix_x     <= (state == PH_ACTIVE && nxt_state == PH_ACTIVE)
                     ? pix_x + CNT_W'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_h_timing_gen.sv
// Directed bench for h_timing_gen: default 800-tick line and a 480-tick
// variant (H_ACTIVE=320) driven in lockstep against a position-based model.
module tb_h_timing_gen;
  import vga_timing_pkg::*;

  logic       clkh = 1'b0;
  logic       clrh;
  logic       pix_en;

  logic [9:0] cntrh_a, pix_x_a, cntrh_b, pix_x_b;
  logic       hs_a, de_a, line_tick_a, hs_b, de_b, line_tick_b;

  int total = 0;
  int bad   = 0;

  int pos_a, pos_b;
  logic lt_a, lt_b;
  int cyc, last_a, last_b, per_a, per_b;
  int de_cnt_b;

  always #5 clkh = ~clkh;

  h_timing_gen dut_a (
    .clkh(clkh), .clrh(clrh), .pix_en(pix_en),
    .cntrh(cntrh_a), .hs(hs_a), .de(de_a), .pix_x(pix_x_a), .line_tick(line_tick_a)
  );

  h_timing_gen #(.H_ACTIVE(320)) dut_b (
    .clkh(clkh), .clrh(clrh), .pix_en(pix_en),
    .cntrh(cntrh_b), .hs(hs_b), .de(de_b), .pix_x(pix_x_b), .line_tick(line_tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one clkh cycle, advance the model at the edge, compare at the negedge.
  task automatic tick(input logic en, input logic rn);
    int exp_px;
    logic exp_de;
    pix_en = en;
    clrh   = rn;
    @(posedge clkh);
    cyc++;
    if (!rn) begin
      pos_a = 0; pos_b = 0; lt_a = 1'b0; lt_b = 1'b0;
      last_a = -1; last_b = -1;
    end else if (en) begin
      lt_a  = (pos_a == 799);
      pos_a = (pos_a + 1) % 800;
      lt_b  = (pos_b == 479);
      pos_b = (pos_b + 1) % 480;
    end else begin
      lt_a = 1'b0; lt_b = 1'b0;
    end
    @(negedge clkh);

    exp_de = (pos_a >= 144) && (pos_a < 784);
    exp_px = exp_de ? pos_a - 144 : 0;
    chk("cntrh_a", cntrh_a, pos_a);
    chk("hs_a", hs_a, (pos_a >= 96) ? 1 : 0);
    chk("de_a", de_a, exp_de);
    chk("pix_x_a", pix_x_a, exp_px);
    chk("line_tick_a", line_tick_a, lt_a);

    exp_de = (pos_b >= 144) && (pos_b < 464);
    exp_px = exp_de ? pos_b - 144 : 0;
    chk("cntrh_b", cntrh_b, pos_b);
    chk("hs_b", hs_b, (pos_b >= 96) ? 1 : 0);
    chk("de_b", de_b, exp_de);
    chk("pix_x_b", pix_x_b, exp_px);
    chk("line_tick_b", line_tick_b, lt_b);

    if (line_tick_a === 1'b1) begin
      if (last_a >= 0) chk("lt_period_a", cyc - last_a, per_a);
      last_a = cyc;
    end
    if (line_tick_b === 1'b1) begin
      if (last_b >= 0) chk("lt_period_b", cyc - last_b, per_b);
      last_b = cyc;
    end
  endtask

  initial begin
    clrh = 1'b0; pix_en = 1'b0;
    pos_a = 0; pos_b = 0; lt_a = 1'b0; lt_b = 1'b0;
    cyc = 0; last_a = -1; last_b = -1; per_a = 800; per_b = 480;
    de_cnt_b = 0;
    @(negedge clkh);

    // Reset with pix_en high: reset wins
    repeat (3) tick(1'b1, 1'b0);
    chk("rst_cntrh", cntrh_a, 0);
    chk("rst_hs", hs_a, 0);
    chk("rst_de", de_a, 0);
    chk("rst_pix_x", pix_x_a, 0);
    chk("rst_line_tick", line_tick_a, 0);

    // Continuous pix_en: line of 800 ticks (480 for the narrow instance)
    tick(1'b1, 1'b1);
    chk("first_tick_cntrh", cntrh_a, 1);
    for (int i = 2; i <= 1700; i++) begin
      tick(1'b1, 1'b1);
      if (i <= 480 && de_b) de_cnt_b++;
      if (i == 144) chk("de_rise", de_a, 1);
      if (i == 784) chk("de_fall", de_a, 0);
      if (i == 800) begin
        chk("wrap_cntrh", cntrh_a, 0);
        chk("wrap_line_tick", line_tick_a, 1);
        chk("wrap_hs", hs_a, 0);
      end
      if (i == 801) chk("wrap_tick_one_cycle", line_tick_a, 0);
    end
    chk("de_b_width", de_cnt_b, 320);

    // pix_en toggling: timing stretched x2
    tick(1'b0, 1'b0);
    per_a = 1600; per_b = 960;
    for (int i = 0; i < 3400; i++) tick((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);

    // Reset mid-line at cntrh=500
    tick(1'b0, 1'b0);
    per_a = 800; per_b = 480;
    repeat (500) tick(1'b1, 1'b1);
    chk("midline_pos", cntrh_a, 500);
    tick(1'b1, 1'b0);
    chk("midrst_cntrh", cntrh_a, 0);
    chk("midrst_de", de_a, 0);
    chk("midrst_hs", hs_a, 0);
    chk("midrst_line_tick", line_tick_a, 0);
    repeat (20) tick(1'b1, 1'b1);

    // Freeze mid-ACTIVE for 50 cycles
    tick(1'b0, 1'b0);
    repeat (300) tick(1'b1, 1'b1);
    repeat (50) tick(1'b0, 1'b1);
    chk("freeze_cntrh", cntrh_a, 300);
    chk("freeze_pix_x", pix_x_a, 156);
    chk("freeze_de", de_a, 1);
    repeat (10) tick(1'b1, 1'b1);
    chk("resume_pix_x", pix_x_a, 166);
    repeat (600) tick(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/h_timing_gen.md
H_TIMING_GEN -- requirements
Module: h_timing_gen

Interface
REQ-001 Parameter H_SYNC, default 96, sync-pulse width in pixel ticks.
REQ-002 Parameter H_BP, default 48, back-porch width in pixel ticks.
REQ-003 Parameter H_ACTIVE, default 640, visible width in pixel ticks.
REQ-004 Parameter H_FP, default 16, front-porch width in pixel ticks.
REQ-005 clkh  input  1  system clock; the single clock; all logic on rising edge.
REQ-006 clrh  input  1  reset, synchronous, active-low.
REQ-007 pix_en  input  1  pixel-tick enable; state advances only on cycles where pix_en=1.
REQ-008 cntrh  output  10  line position, 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800).
REQ-009 hs  output  1  horizontal sync, active-low, 0 during SYNC phase.
REQ-010 de  output  1  display enable, 1 during ACTIVE phase only.
REQ-011 pix_x  output  10  visible column, 0..H_ACTIVE-1 while de=1, held at 0 otherwise.
REQ-012 line_tick  output  1  one-clkh-cycle pulse at end of line; drives the vertical counter's clock/enable.

Function
REQ-013 Phase FSM states: SYNC, BACK, ACTIVE, FRONT; order SYNC->BACK->ACTIVE->FRONT->SYNC.
REQ-014 Phase counter counts pix_en ticks within a phase; transition when phase counter = phase width-1 and pix_en=1; phase counter then clears to 0.
REQ-015 cntrh increments by 1 on each pix_en tick, wraps H_TOTAL-1 -> 0 on the same tick the FSM leaves FRONT.
REQ-016 All outputs registered; hs/de/pix_x reflect the state and position held in the same cycle (no extra latency beyond the register).
REQ-017 line_tick = 1 for exactly one clkh cycle: the cycle following the pix_en tick on which cntrh wraps to 0; 0 otherwise.
REQ-018 pix_x increments on each pix_en tick within ACTIVE; returns to 0 on exit from ACTIVE.
REQ-019 pix_en=0: all state, counters and outputs hold; line_tick not reasserted.
REQ-020 pix_en continuously 1: line_tick period exactly H_TOTAL clkh cycles.
REQ-021 Counter widths 10 bits; H_TOTAL > 1024 is unsupported (elaboration-time check).

Reset
REQ-022 clrh=0 at a rising clkh edge: FSM=SYNC, phase counter=0, cntrh=0, hs=0, de=0, pix_x=0, line_tick=0.
REQ-023 Reset has priority over pix_en; reset mid-line aborts the line with no line_tick emitted.
REQ-024 First pix_en tick after reset release advances cntrh to 1.

Structure
REQ-025 Shared package vga_timing_pkg holds the phase enum and default H_* constants, reused by the vertical stage.
REQ-026 No sub-module; FSM and counters in one module.

Verification
REQ-027 Reset release, pix_en=1 constant -> hs=0 for cntrh 0..95, de=1 for cntrh 144..783, line_tick high once at cycle 800.
REQ-028 pix_en toggling 1/0 -> all timing stretched x2; line_tick period 1600 clkh cycles; pix_x 0..639 monotonic, no skips.
REQ-029 clrh=0 asserted at cntrh=500 -> next cycle cntrh=0, de=0, hs=0, no line_tick pulse.
REQ-030 Wrap boundary: cntrh=799 with pix_en=1 -> cntrh=0, state=SYNC, line_tick=1 one cycle, hs falls.
REQ-031 pix_en held 0 for 50 cycles mid-ACTIVE -> pix_x, cntrh, de frozen; resume continues from held values.
REQ-032 Override H_ACTIVE=320 -> de high 320 ticks, line_tick period 480 ticks.
